pid_sched: RTL and testbench
============================

# pid_sched

Sequencer that time-shares one multi-context PID core across NCH control channels. It latches per-channel measurements and starts a sweep on every loop-period tick. The sweep issues one iterate per pending channel and captures each result into a per-channel output register. Host configuration writes are forwarded to the core only while it is idle. The block sits between the sensor/host interfaces and the PID core.

## Interface
- D_WIDTH, 16, data width of target, measurement, config and result words
- NCH, 4, number of channels / core contexts (≥2)
- PERIOD_CYCLES, 1000, loop period in clk cycles (≥ NCH*4)
- TIMEOUT_CYCLES, 64, watchdog limit for a core response (used only with PID_SCHED_WDT_EN)

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- cfg_wr_en  in  1  host write request
- cfg_addr  in  D_WIDTH  host register address
- cfg_data  in  D_WIDTH  host register data
- cfg_ready  out  1  write accepted when cfg_wr_en && cfg_ready
- meas_valid  in  NCH  per-channel measurement strobe
- meas_data  in  NCH*D_WIDTH  per-channel measurement, channel i at [i*D_WIDTH +: D_WIDTH]
- target_data  in  NCH*D_WIDTH  per-channel setpoint, sampled at issue
- core_write_enable  out  1  config write pulse to core
- core_reg_addr  out  D_WIDTH  forwarded cfg_addr
- core_reg_data  out  D_WIDTH  forwarded cfg_data
- core_iterate_enable  out  1  iterate pulse to core
- core_ch  out  $clog2(NCH)  core context select
- core_target  out  D_WIDTH  setpoint to core
- core_measurement  out  D_WIDTH  measurement to core
- core_out  in  D_WIDTH  core result
- core_out_valid  in  1  core result strobe
- ch_out  out  NCH*D_WIDTH  registered per-channel result
- ch_out_valid  out  NCH  one-cycle per-channel result-update pulse
- overrun  out  1  sticky: a tick arrived while a sweep was active
- timeout_err  out  NCH  sticky per-channel watchdog flag

## Operation
- Period counter counts 0..PERIOD_CYCLES-1 and wraps; tick is asserted in the cycle count == PERIOD_CYCLES-1.
- Measurement latch: meas_valid[i] stores meas_data slice i and sets pending[i]. Always active, including during a sweep.
- FSM states: IDLE, CFG, SCAN, ISSUE, WAIT.
- IDLE:
  - tick → SCAN with ch=0.
  - Otherwise, an accepted write → CFG.
  - cfg_ready = (state==IDLE) && !tick. On a tick/write collision, the tick wins and the write stalls.
- CFG: core_write_enable=1 for exactly one cycle with the captured addr/data; → IDLE.
- SCAN, one cycle per channel:
  - pending[ch] → ISSUE.
  - Else if ch==NCH-1 → IDLE.
  - Else ch+1, stay in SCAN.
- ISSUE: core_iterate_enable=1 for one cycle; clear pending[ch]; → WAIT. If meas_valid[ch] in the same cycle, the new value is stored and pending stays 1 (served next sweep).
- WAIT:
  - On core_out_valid: capture core_out into ch_out slice ch; pulse ch_out_valid[ch] the next cycle.
  - Then ch==NCH-1 → IDLE, else ch+1 → SCAN.
  - core_out_valid outside WAIT is ignored.
- Tick while state≠IDLE: set overrun; tick dropped; current sweep continues.
- core_ch, core_target and core_measurement are registered at ISSUE entry and held stable through WAIT.
- overrun and timeout_err clear only on reset.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; pending 0; ch 0.
- Reset asserted mid-sweep: all state cleared immediately, and the core pulses drop asynchronously.
- Tick → first core_iterate_enable: 2 cycles (SCAN, ISSUE) for channel 0 pending.
- core_out_valid → ch_out updated and ch_out_valid high: 1 cycle.
- Skipped channel costs 1 cycle; served channel costs 2 + core latency + 1 cycles.
- Accepted write → core_write_enable: next cycle. cfg_ready is low during CFG, so back-to-back writes have a throughput of 1 per 2 cycles.

## Configuration
- PID_SCHED_WDT_EN defined:
  - WAIT counts cycles.
  - After TIMEOUT_CYCLES cycles without core_out_valid: set timeout_err[ch], leave ch_out unchanged with no pulse, advance as if a response had arrived.
- Undefined: WAIT waits indefinitely; timeout_err is tied to 0 and TIMEOUT_CYCLES is unused.

## Structure
- Shared package pid_pkg: D_WIDTH default, state enum (IDLE, CFG, SCAN, ISSUE, WAIT), channel-index typedef helper.
- Sub-module pid_sched_tick: period counter plus tick output, parameterised by PERIOD_CYCLES.

## Test plan
- Reset, NCH=4, PERIOD_CYCLES=40:
  - Stimulus: meas_valid[2] with 0x0800, core responds 3 cycles after iterate with 0x1234.
  - Response: core_ch=2 and core_measurement=0x0800 at iterate; ch_out slice 2 = 0x1234 with ch_out_valid[2]; no pulse on other channels.
- All 4 pending, core latency 20, PERIOD_CYCLES=40 → second tick during sweep sets overrun=1; sweep completes all 4 channels.
- cfg_wr_en with addr 0x0003, data 0x2000 in IDLE → core_write_enable one cycle later with the same addr/data. The same request on the tick cycle → cfg_ready=0, accepted after the sweep.
- meas_valid[1] with 0x0100 in ch1's ISSUE cycle → iterate uses the old value; the next sweep issues 0x0100.
- With PID_SCHED_WDT_EN, TIMEOUT_CYCLES=64, core silent on ch0 → timeout_err[0]=1 after 64 WAIT cycles; ch1 is then served normally.
- rstb low during WAIT → all outputs 0. After release, there is no iterate until a new measurement plus tick.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared types and constants for the pid_sched sequencer.
package pid_pkg;

    localparam int D_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4
    } pid_state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_bits(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/pid_sched_tick.sv
// pid_sched_tick: free-running loop-period counter 0..PERIOD_CYCLES-1.
// o_tick is high during the last count of each period.
module pid_sched_tick
    import pid_pkg::*;
#(
    parameter int PERIOD_CYCLES = 1000
) (
    input  logic clk,
    input  logic rstb,
    output logic o_tick
);

    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Count up and wrap at the end of the period.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_count <= '0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/pid_sched.sv
// pid_sched: time-shares one multi-context PID core across NCH channels.
// Each loop tick starts a sweep that issues one iterate per pending channel
// and stores the core's answer in that channel's output register. Host
// config writes are forwarded to the core only between sweeps.
// Optional core-response watchdog: define PID_SCHED_WDT_EN.
module pid_sched
    import pid_pkg::*;
#(
    parameter int D_WIDTH        = D_WIDTH_DEF,
    parameter int NCH            = 4,
    parameter int PERIOD_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     cfg_wr_en,
    input  logic [D_WIDTH-1:0]       cfg_addr,
    input  logic [D_WIDTH-1:0]       cfg_data,
    output logic                     cfg_ready,
    input  logic [NCH-1:0]           meas_valid,
    input  logic [NCH*D_WIDTH-1:0]   meas_data,
    input  logic [NCH*D_WIDTH-1:0]   target_data,
    output logic                     core_write_enable,
    output logic [D_WIDTH-1:0]       core_reg_addr,
    output logic [D_WIDTH-1:0]       core_reg_data,
    output logic                     core_iterate_enable,
    output logic [$clog2(NCH)-1:0]   core_ch,
    output logic [D_WIDTH-1:0]       core_target,
    output logic [D_WIDTH-1:0]       core_measurement,
    input  logic [D_WIDTH-1:0]       core_out,
    input  logic                     core_out_valid,
    output logic [NCH*D_WIDTH-1:0]   ch_out,
    output logic [NCH-1:0]           ch_out_valid,
    output logic                     overrun,
    output logic [NCH-1:0]           timeout_err
);

    localparam int CHW = ch_idx_bits(NCH);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

    pid_state_t             r_state, w_state_next;
    logic [CHW-1:0]         r_ch, w_ch_next;
    logic [NCH-1:0]         r_pending;
    logic [D_WIDTH-1:0]     r_meas [NCH];
    logic [D_WIDTH-1:0]     r_cfg_addr, r_cfg_data;
    logic [CHW-1:0]         r_core_ch;
    logic [D_WIDTH-1:0]     r_core_target, r_core_meas;
    logic [NCH*D_WIDTH-1:0] r_ch_out;
    logic [NCH-1:0]         r_ch_out_valid;
    logic                   r_overrun;
    logic                   w_tick, w_cfg_ready, w_cfg_accept;
    logic                   w_issue_load, w_capture, w_wdt_expired;

    pid_sched_tick #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
        .clk    (clk),
        .rstb   (rstb),
        .o_tick (w_tick)
    );

    // Host handshake: a write transfers in any cycle where cfg_wr_en and
    // cfg_ready are both high; cfg_wr_en/addr/data must hold until then.
    // A tick in the same cycle takes priority, so the write waits out the sweep.
    assign w_cfg_ready  = (r_state == ST_IDLE) && !w_tick;
    assign w_cfg_accept = cfg_wr_en && w_cfg_ready;
    assign cfg_ready    = rstb && w_cfg_ready;

    // Next state, next channel and the one-cycle datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_issue_load = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_next = ST_SCAN;
                    w_ch_next    = '0;
                end else if (w_cfg_accept) begin
                    w_state_next = ST_CFG;
                end
            end
            ST_CFG: w_state_next = ST_IDLE;
            ST_SCAN: begin
                if (r_pending[r_ch]) begin
                    w_state_next = ST_ISSUE;
                    w_issue_load = 1'b1;
                end else if (r_ch == LAST_CH) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_ch_next = r_ch + 1'b1;
                end
            end
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT: begin
                w_capture = core_out_valid;
                if (core_out_valid || w_wdt_expired) begin
                    if (r_ch == LAST_CH) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_SCAN;
                        w_ch_next    = r_ch + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and current-channel registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_next;
            r_ch    <= w_ch_next;
        end
    end

    // Measurement latch; a new sample in the issue cycle keeps the channel pending.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_pending <= '0;
            for (int i = 0; i < NCH; i++) r_meas[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (meas_valid[i]) begin
                    r_meas[i]    <= meas_data[i*D_WIDTH +: D_WIDTH];
                    r_pending[i] <= 1'b1;
                end else if ((r_state == ST_ISSUE) && (r_ch == CHW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Capture the host write so the core sees it during the CFG cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cfg_addr <= '0;
            r_cfg_data <= '0;
        end else if (w_cfg_accept) begin
            r_cfg_addr <= cfg_addr;
            r_cfg_data <= cfg_data;
        end
    end

    // Core operands are frozen on the way into ISSUE and held through WAIT.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_core_ch     <= '0;
            r_core_target <= '0;
            r_core_meas   <= '0;
        end else if (w_issue_load) begin
            r_core_ch     <= r_ch;
            r_core_target <= target_data[int'(r_ch)*D_WIDTH +: D_WIDTH];
            r_core_meas   <= r_meas[r_ch];
        end
    end

    // Store the core result and pulse the matching channel's valid once.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ch_out       <= '0;
            r_ch_out_valid <= '0;
        end else begin
            r_ch_out_valid <= '0;
            if (w_capture) begin
                r_ch_out[int'(r_ch)*D_WIDTH +: D_WIDTH] <= core_out;
                r_ch_out_valid[r_ch]                   <= 1'b1;
            end
        end
    end

    // Sticky overrun: a tick seen while a sweep or write is still in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_overrun <= 1'b0;
        end else if (w_tick && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

`ifdef PID_SCHED_WDT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]  r_wdt_cnt;
    logic [NCH-1:0] r_timeout_err;

    // Count WAIT cycles; any other state restarts the count.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wdt_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end
    end

    assign w_wdt_expired = (r_state == ST_WAIT) && (r_wdt_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Flag the silent channel; the sweep moves on without touching ch_out.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_timeout_err <= '0;
        end else if (w_wdt_expired && !core_out_valid) begin
            r_timeout_err[r_ch] <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // No watchdog: WAIT lasts until the core answers and the flags stay clear.
    assign w_wdt_expired = 1'b0;
    assign timeout_err   = {NCH{TIMEOUT_CYCLES < 0}};
`endif

    assign core_write_enable   = (r_state == ST_CFG);
    assign core_reg_addr       = r_cfg_addr;
    assign core_reg_data       = r_cfg_data;
    assign core_iterate_enable = (r_state == ST_ISSUE);
    assign core_ch             = r_core_ch;
    assign core_target         = r_core_target;
    assign core_measurement    = r_core_meas;
    assign ch_out              = r_ch_out;
    assign ch_out_valid        = r_ch_out_valid;
    assign overrun             = r_overrun;

endmodule

// File: tb/tb_pid_sched.sv
// tb_pid_sched: directed bench for pid_sched with NCH=4, PERIOD_CYCLES=40.
module tb_pid_sched;

    localparam int D_WIDTH = 16;
    localparam int NCH     = 4;
    localparam int PERIOD  = 40;
    localparam int TMO     = 64;
    localparam int SBW     = 2 + D_WIDTH;   // {channel, word}

    logic                   clk = 1'b0;
    logic                   rstb = 1'b0;
    logic                   cfg_wr_en = 1'b0;
    logic [D_WIDTH-1:0]     cfg_addr = '0;
    logic [D_WIDTH-1:0]     cfg_data = '0;
    logic                   cfg_ready;
    logic [NCH-1:0]         meas_valid = '0;
    logic [NCH*D_WIDTH-1:0] meas_data = '0;
    logic [NCH*D_WIDTH-1:0] target_data = '0;
    logic                   core_write_enable;
    logic [D_WIDTH-1:0]     core_reg_addr, core_reg_data;
    logic                   core_iterate_enable;
    logic [1:0]             core_ch;
    logic [D_WIDTH-1:0]     core_target, core_measurement;
    logic [D_WIDTH-1:0]     core_out = '0;
    logic                   core_out_valid = 1'b0;
    logic [NCH*D_WIDTH-1:0] ch_out;
    logic [NCH-1:0]         ch_out_valid;
    logic                   overrun;
    logic [NCH-1:0]         timeout_err;

    int               n_vec = 0;
    int               n_bad = 0;
    logic [SBW-1:0]   exp_q[$];     // expected ch_out_valid pulses {ch, ch_out slice}
    logic [SBW-1:0]   iter_q[$];    // expected iterates {core_ch, core_measurement}
    int               tb_cnt;
    logic [NCH-1:0]   resp_mask = '1;
    int               resp_lat = 3;
    logic [D_WIDTH-1:0] resp_val [NCH];
    int               rc;
    bit               hit;
    int               n;

    pid_sched #(
        .D_WIDTH(D_WIDTH), .NCH(NCH), .PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstb(rstb),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .meas_valid(meas_valid), .meas_data(meas_data), .target_data(target_data),
        .core_write_enable(core_write_enable), .core_reg_addr(core_reg_addr),
        .core_reg_data(core_reg_data), .core_iterate_enable(core_iterate_enable),
        .core_ch(core_ch), .core_target(core_target), .core_measurement(core_measurement),
        .core_out(core_out), .core_out_valid(core_out_valid),
        .ch_out(ch_out), .ch_out_valid(ch_out_valid),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Position within the loop period, counted from reset release.
    always @(posedge clk or negedge rstb) begin
        if (!rstb) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors so far", n_vec);
        $fatal(1);
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_meas(input int ch, input logic [D_WIDTH-1:0] v);
        meas_data[ch*D_WIDTH +: D_WIDTH] = v;
        meas_valid[ch] = 1'b1;
        step();
        meas_valid[ch] = 1'b0;
    endtask

    task automatic wait_iter(input int max_cyc, output bit found);
        found = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (core_iterate_enable) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            if (iter_q.size() == 0 && exp_q.size() == 0) break;
            step();
        end
        check(tag, iter_q.size() + exp_q.size(), 0);
        step();
        step();
    endtask

    // ---------------- core model ----------------
    // Answers each iterate resp_lat cycles later with resp_val[ch], unless masked.
    initial begin : core_model
        forever begin
            @(negedge clk);
            if (rstb && core_iterate_enable && resp_mask[core_ch]) begin
                rc = int'(core_ch);
                repeat (resp_lat) @(posedge clk);
                #1;
                core_out       = resp_val[rc];
                core_out_valid = 1'b1;
                @(posedge clk);
                #1;
                core_out_valid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rstb && core_iterate_enable) begin
                if (iter_q.size() > 0) check("iterate", {core_ch, core_measurement}, iter_q.pop_front());
                else                   check("iter_unexp", core_iterate_enable, 1'b0);
            end
            for (int i = 0; i < NCH; i++) begin
                if (ch_out_valid[i]) begin
                    if (exp_q.size() > 0) check("result", {2'(i), ch_out[i*D_WIDTH +: D_WIDTH]}, exp_q.pop_front());
                    else                  check("res_unexp", ch_out_valid[i], 1'b0);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < NCH; i++) resp_val[i] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {cfg_ready, core_write_enable, core_iterate_enable, ch_out_valid, overrun, timeout_err}, '0);
        check("rst_core", {core_ch, core_target, core_measurement, core_reg_addr, core_reg_data}, '0);
        check("rst_ch_out", ch_out, '0);
        @(posedge clk);
        #1;
        rstb = 1'b1;

        // Single channel: ch2 measured 0x0800, core answers 0x1234 after 3 cycles
        target_data[2*D_WIDTH +: D_WIDTH] = 16'h0555;
        resp_val[2] = 16'h1234;
        iter_q.push_back({2'd2, 16'h0800});
        exp_q.push_back({2'd2, 16'h1234});
        step();
        pulse_meas(2, 16'h0800);
        wait_iter(2 * PERIOD, hit);
        check("t1_hit", hit, 1'b1);
        check("t1_lat", tb_cnt, 3);
        check("t1_target", core_target, 16'h0555);
        step();
        step();
        check("t1_hold", {core_ch, core_measurement}, {2'd2, 16'h0800});
        wait_drain("t1_drain", 20);
        check("t1_ch_out", ch_out, 64'h0000_1234_0000_0000);

        // Config write in IDLE
        for (int k = 0; k < PERIOD && !(tb_cnt >= 2 && tb_cnt <= 30); k++) step();
        cfg_addr  = 16'h0003;
        cfg_data  = 16'h2000;
        cfg_wr_en = 1'b1;
        @(negedge clk);
        check("wr_ready", cfg_ready, 1'b1);
        step();
        cfg_wr_en = 1'b0;
        @(negedge clk);
        check("wr_pulse", {core_write_enable, core_reg_addr, core_reg_data}, {1'b1, 16'h0003, 16'h2000});
        step();
        @(negedge clk);
        check("wr_once", core_write_enable, 1'b0);

        // Write on the tick cycle stalls through an empty sweep (4 SCAN cycles)
        step();
        for (int k = 0; k < PERIOD + 2 && tb_cnt != PERIOD - 1; k++) step();
        cfg_addr  = 16'h0007;
        cfg_data  = 16'h00AA;
        cfg_wr_en = 1'b1;
        @(negedge clk);
        check("col_stall", cfg_ready, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_ready && n < 20);
        check("col_wait", n, 5);
        step();
        cfg_wr_en = 1'b0;
        @(negedge clk);
        check("col_pulse", {core_write_enable, core_reg_addr, core_reg_data}, {1'b1, 16'h0007, 16'h00AA});

        // New ch1 sample in ch1's ISSUE cycle: old value now, new value next sweep
        resp_val[1] = 16'h0BEE;
        iter_q.push_back({2'd1, 16'h0011});
        exp_q.push_back({2'd1, 16'h0BEE});
        iter_q.push_back({2'd1, 16'h0100});
        exp_q.push_back({2'd1, 16'h0BEE});
        step();
        pulse_meas(1, 16'h0011);
        for (int k = 0; k < 2 * PERIOD && !core_iterate_enable; k++) step();
        meas_data[1*D_WIDTH +: D_WIDTH] = 16'h0100;
        meas_valid[1] = 1'b1;
        step();
        meas_valid[1] = 1'b0;
        wait_drain("iss_drain", 3 * PERIOD);

        // All four pending, latency 20: sweep outlasts the period
        @(negedge clk);
        check("ovr_before", overrun, 1'b0);
        resp_lat = 20;
        for (int i = 0; i < NCH; i++) begin
            resp_val[i] = 16'hA000 + 16'(i);
            meas_data[i*D_WIDTH +: D_WIDTH] = 16'h0010 * 16'(i + 1);
            iter_q.push_back({2'(i), 16'h0010 * 16'(i + 1)});
            exp_q.push_back({2'(i), 16'hA000 + 16'(i)});
        end
        step();
        meas_valid = 4'hF;
        step();
        meas_valid = '0;
        wait_iter(2 * PERIOD, hit);
        check("ovr_lat", tb_cnt, 1);
        step();
        wait_drain("ovr_drain", 4 * PERIOD);
        @(negedge clk);
        check("overrun", overrun, 1'b1);
        check("ovr_ch_out", ch_out, 64'hA003_A002_A001_A000);
        resp_lat = 3;

`ifdef PID_SCHED_WDT_EN
        // Core silent on ch0: watchdog flags it, ch1 still served
        resp_mask   = 4'b1110;
        resp_val[1] = 16'h0C01;
        iter_q.push_back({2'd0, 16'h0044});
        iter_q.push_back({2'd1, 16'h0055});
        exp_q.push_back({2'd1, 16'h0C01});
        step();
        meas_data[0 +: D_WIDTH]       = 16'h0044;
        meas_data[D_WIDTH +: D_WIDTH] = 16'h0055;
        meas_valid = 4'b0011;
        step();
        meas_valid = '0;
        wait_drain("tmo_drain", 5 * PERIOD);
        @(negedge clk);
        check("tmo_err", timeout_err, 4'b0001);
        check("tmo_ch0", ch_out[0 +: D_WIDTH], 16'hA000);
        resp_mask = '1;
`else
        @(negedge clk);
        check("tmo_tied", timeout_err, 4'b0000);
`endif

        // Reset while waiting on a silent core
        resp_mask = '0;
        iter_q.push_back({2'd3, 16'h0077});
        step();
        pulse_meas(3, 16'h0077);
        wait_iter(2 * PERIOD, hit);
        check("rw_hit", hit, 1'b1);
        step();
        step();
        rstb = 1'b0;
        #1;
        check("rw_flags", {cfg_ready, core_write_enable, core_iterate_enable, ch_out_valid, overrun, timeout_err}, '0);
        check("rw_core", {core_ch, core_target, core_measurement, core_reg_addr, core_reg_data}, '0);
        check("rw_ch_out", ch_out, '0);
        step();
        step();
        rstb = 1'b1;
        resp_mask = '1;
        repeat (3 * PERIOD) step();
        @(negedge clk);
        check("rw_after", {ch_out, overrun}, '0);
        check("sb_empty", iter_q.size() + exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
